jtcps1_linefb: RTL and testbench

Line capture and drain stage downstream of the CPS1 video pipeline. It captures the 12-bit pixel stream of each visible line into one of two ping-pong line buffers. While the next line is being captured, it drains the completed line to the external frame-buffer writer over a `line_wr`/`line_wr_ok` handshake. This decouples pixel-rate video from the variable-latency frame-buffer memory and reports lines dropped under back-pressure.

---
 rtl/jtcps1_linefb_pkg.sv | 20 ++
 rtl/jtcps1_linefb_ram.sv | 36 +++
 rtl/jtcps1_linefb.sv | 133 +++++++++++++
 tb/tb_jtcps1_linefb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps1_linefb_pkg.sv
// +------------------------------------------------------------------+
// | jtcps1_linefb_pkg: shared encodings and defaults for line buffer |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package jtcps1_linefb_pkg;
    localparam int         ACTIVE_DEF = 384;
    localparam int         DW_DEF     = 12;
    localparam int         AW_DEF     = 9;
    localparam logic [7:0] DROP_MAX   = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } drain_st_t;
endpackage

`default_nettype wire

// File: rtl/jtcps1_linefb_ram.sv
// +------------------------------------------------------------------+
// | jtcps1_linefb_ram: two-bank line store, registered read port     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module jtcps1_linefb_ram #(
    parameter int ACTIVE = 384,
    parameter int DW     = 12,
    parameter int AW     = 9
)(
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic          re,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_col,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [2][ACTIVE];

    always_ff @(posedge clk) begin
        if (we) mem[wr_bank][wr_col] <= wr_data;
    end

    // Only the output register is reset so line_data starts at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   rd_data <= '0;
        else if (re) rd_data <= mem[rd_bank][rd_col];
    end
endmodule

`default_nettype wire

// File: rtl/jtcps1_linefb.sv
// +------------------------------------------------------------------+
// | jtcps1_linefb: ping-pong line capture and handshake drain        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module jtcps1_linefb
    import jtcps1_linefb_pkg::*;
#(
    parameter int ACTIVE = ACTIVE_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF
)(
    input  logic          clk,
    input  logic          rstn,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic [8:0]    vdump,
    input  logic [DW-1:0] pxl_in,
    output logic [DW-1:0] line_data,
    output logic [AW-1:0] line_addr,
    output logic [8:0]    line_vpos,
    output logic          line_wr,
    input  logic          line_wr_ok,
    output logic          busy,
    output logic [7:0]    drop_cnt
);
    localparam logic [AW:0] ACT = (AW+1)'(ACTIVE);

    logic [AW:0]   cap_col, len;
    logic          cap_bank, drn_bank, lhbl_l;
    logic [1:0]    full, full_nxt;
    logic [8:0]    vpos;
    logic [AW-1:0] col, col_nxt;
    drain_st_t     st, st_nxt;
    logic          cap_we, commit, accept, drop, rel, rd_en, last;

    assign cap_we = pxl_cen & LHBL & LVBL & (cap_col < ACT);
    assign commit = pxl_cen & lhbl_l & ~LHBL & LVBL;
    assign last   = ({1'b0, col} == len - 1'b1);
    // A release in this cycle frees the drain bank before the commit looks at it.
    assign accept = commit & (cap_col != '0) & (~full[~cap_bank] | rel);
    assign drop   = commit & (cap_col != '0) & ~accept;

    always_comb begin
        full_nxt = full;
        if (rel)    full_nxt[drn_bank] = 1'b0;
        if (accept) full_nxt[cap_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_col  <= '0;
            cap_bank <= 1'b0;
            lhbl_l   <= 1'b0;
            full     <= '0;
            len      <= '0;
            vpos     <= '0;
            drop_cnt <= '0;
        end else begin
            if (pxl_cen) lhbl_l <= LHBL;
            if (commit)      cap_col <= '0;
            else if (cap_we) cap_col <= cap_col + 1'b1;
            if (accept) begin
                len      <= cap_col;
                vpos     <= vdump;
                cap_bank <= ~cap_bank;
            end
            if (drop && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
            full <= full_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= ST_IDLE;
            col      <= '0;
            drn_bank <= 1'b0;
        end else begin
            st  <= st_nxt;
            col <= col_nxt;
            if (st == ST_IDLE && st_nxt == ST_RD) drn_bank <= ~cap_bank;
        end
    end

    always_comb begin
        st_nxt  = st;
        col_nxt = col;
        rel     = 1'b0;
        rd_en   = 1'b0;
        unique case (st)
            ST_IDLE: if (full[~cap_bank]) begin
                st_nxt  = ST_RD;
                col_nxt = '0;
            end
            ST_RD: begin
                rd_en  = 1'b1;
                st_nxt = ST_WR;
            end
            ST_WR: if (line_wr_ok) begin
                if (last) begin
                    rel    = 1'b1;
                    st_nxt = ST_IDLE;
                end else begin
                    col_nxt = col + 1'b1;
                    st_nxt  = ST_RD;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    jtcps1_linefb_ram #(.ACTIVE(ACTIVE), .DW(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .we      (cap_we),
        .wr_bank (cap_bank),
        .wr_col  (cap_col[AW-1:0]),
        .wr_data (pxl_in),
        .re      (rd_en),
        .rd_bank (drn_bank),
        .rd_col  (col),
        .rd_data (line_data)
    );

    assign line_wr   = (st == ST_WR);
    assign busy      = (st != ST_IDLE);
    assign line_addr = col;
    assign line_vpos = vpos;
endmodule

`default_nettype wire

// File: tb/tb_jtcps1_linefb.sv
// +------------------------------------------------------------------+
// | tb_jtcps1_linefb: randomized bench with queue-based line model   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_jtcps1_linefb;
    localparam int ACTIVE = 384;
    localparam int DW     = 12;
    localparam int AW     = 9;

    logic          clk = 1'b0, rstn = 1'b0, pxl_cen = 1'b0;
    logic          LHBL = 1'b0, LVBL = 1'b1, line_wr_ok = 1'b0;
    logic [8:0]    vdump = '0;
    logic [DW-1:0] pxl_in = '0;
    logic [DW-1:0] line_data;
    logic [AW-1:0] line_addr;
    logic [8:0]    line_vpos;
    logic          line_wr, busy;
    logic [7:0]    drop_cnt;

    jtcps1_linefb dut (
        .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .vdump(vdump), .pxl_in(pxl_in), .line_data(line_data), .line_addr(line_addr),
        .line_vpos(line_vpos), .line_wr(line_wr), .line_wr_ok(line_wr_ok),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [8:0]    vpos;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] cap_q[$];
    int  checks = 0, failures = 0;
    int  cyc = 0, acc_cyc = -10, m_drop = 0, nwr = 0, ack_mode = 0;
    bit  m_lhbl_l = 1'b0;
    logic p_wr = 1'b0, p_ok = 1'b0;
    wr_t p_w, first_w, last_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acknowledge pattern: 0 tied high, 1 every 5th cycle, 2 random, 3 stalled
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       line_wr_ok = 1'b1;
            1:       line_wr_ok = (cyc % 5 == 0);
            2:       line_wr_ok = ($urandom_range(0, 2) == 0);
            default: line_wr_ok = 1'b0;
        endcase
    end

    // Model: a line becomes a list of expected writes; the drain bank is free exactly when that list is empty.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!rstn) begin
            exp_q.delete();
            cap_q.delete();
            m_drop   = 0;
            m_lhbl_l = 1'b0;
            acc_cyc  = -10;
            p_wr     = 1'b0;
            p_ok     = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'((exp_q.size() != 0) && (cyc != acc_cyc + 1)));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (exp_q.size() == 0) chk("wr_without_line", 32'(line_wr), 32'd0);
            if (cyc == acc_cyc + 2) chk("wr_before_read", 32'(line_wr), 32'd0);
            if (cyc == acc_cyc + 3) chk("wr_rise_latency", 32'(line_wr), 32'd1);
            if (p_wr && p_ok) chk("wr_after_ack", 32'(line_wr), 32'd0);
            if (p_wr && !p_ok && line_wr) begin
                chk("hold_addr", 32'(line_addr), 32'(p_w.addr));
                chk("hold_data", 32'(line_data), 32'(p_w.data));
                chk("hold_vpos", 32'(line_vpos), 32'(p_w.vpos));
            end
            if (line_wr && line_wr_ok && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(line_addr), 32'(e.addr));
                chk("wr_data", 32'(line_data), 32'(e.data));
                chk("wr_vpos", 32'(line_vpos), 32'(e.vpos));
                if (nwr == 0) first_w = {line_addr, line_data, line_vpos};
                last_w = {line_addr, line_data, line_vpos};
                nwr++;
            end
            if (pxl_cen) begin
                if (m_lhbl_l && !LHBL && LVBL) begin
                    if (cap_q.size() != 0) begin
                        if (exp_q.size() == 0) begin
                            for (int i = 0; i < cap_q.size(); i++) begin
                                e = {AW'(i), cap_q[i], vdump};
                                exp_q.push_back(e);
                            end
                            acc_cyc = cyc;
                        end else if (m_drop < 255) begin
                            m_drop++;
                        end
                    end
                    cap_q.delete();
                end else if (LHBL && LVBL && cap_q.size() < ACTIVE) begin
                    cap_q.push_back(pxl_in);
                end
                m_lhbl_l = LHBL;
            end
            p_wr = line_wr;
            p_ok = line_wr_ok;
            p_w  = {line_addr, line_data, line_vpos};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int npix, input int vp, input bit seq, input int blank);
        int c = 0;
        LHBL  = 1'b1;
        vdump = 9'(vp);
        while (c < npix) begin
            pxl_cen = ($urandom_range(0, 3) != 0);
            pxl_in  = seq ? DW'(c) : DW'($urandom);
            if (pxl_cen) c++;
            tick();
        end
        LHBL    = 1'b0;
        pxl_cen = 1'b1;
        tick();
        for (int i = 0; i < blank; i++) begin
            pxl_cen = $urandom_range(0, 1) == 1;
            tick();
        end
        pxl_cen = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy) return;
            tick();
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout: still busy after %0d cycles", budget);
    endtask

    initial begin
        bit found;
        repeat (3) tick();
        chk("rst_line_wr", 32'(line_wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(line_addr), 32'd0);
        chk("rst_data", 32'(line_data), 32'd0);
        chk("rst_vpos", 32'(line_vpos), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rstn = 1'b1;
        tick();

        // Full line, acknowledge tied high
        ack_mode = 0;
        nwr = 0;
        run_line(384, 20, 1'b1, 4);
        wait_drain(2000);
        chk("full_count", 32'(nwr), 32'd384);
        chk("full_first_addr", 32'(first_w.addr), 32'd0);
        chk("full_first_data", 32'(first_w.data), 32'd0);
        chk("full_vpos", 32'(first_w.vpos), 32'd20);
        chk("full_last_addr", 32'(last_w.addr), 32'd383);
        chk("full_last_data", 32'(last_w.data), 32'd383);
        chk("full_busy_end", 32'(busy), 32'd0);

        // Slow acknowledges while the next line captures, then a full stall
        ack_mode = 1;
        run_line(200, 21, 1'b0, 600);
        run_line(300, 22, 1'b0, 50);
        wait_drain(3000);
        chk("bp_no_drop", 32'(drop_cnt), 32'd0);
        ack_mode = 3;
        nwr = 0;
        run_line(50, 23, 1'b0, 20);
        run_line(50, 24, 1'b0, 20);
        chk("stall_drop", 32'(drop_cnt), 32'd1);
        ack_mode = 0;
        wait_drain(500);
        chk("stall_count", 32'(nwr), 32'd50);
        chk("stall_vpos", 32'(last_w.vpos), 32'd23);

        // Overlong, short and empty lines
        nwr = 0;
        run_line(400, 30, 1'b1, 10);
        wait_drain(2000);
        chk("long_count", 32'(nwr), 32'd384);
        chk("long_last_data", 32'(last_w.data), 32'd383);
        nwr = 0;
        run_line(100, 31, 1'b0, 10);
        wait_drain(1000);
        chk("short_count", 32'(nwr), 32'd100);
        nwr = 0;
        LVBL = 1'b0; LHBL = 1'b1; pxl_cen = 1'b1;
        repeat (3) tick();
        LVBL = 1'b1; LHBL = 1'b0;
        tick();
        pxl_cen = 1'b0;
        repeat (10) tick();
        chk("empty_count", 32'(nwr), 32'd0);

        // Vertical blank: drain finishes, nothing commits
        ack_mode = 2;
        nwr = 0;
        run_line(384, 40, 1'b0, 5);
        LVBL = 1'b0;
        for (int i = 0; i < 16; i++) run_line(100, 41 + i, 1'b0, 20);
        chk("vb_count", 32'(nwr), 32'd384);
        chk("vb_busy", 32'(busy), 32'd0);
        chk("vb_drop", 32'(drop_cnt), 32'd1);
        LVBL = 1'b1;

        // Saturation under a permanent stall
        ack_mode = 3;
        for (int i = 0; i < 300; i++) run_line(4, i % 256, 1'b0, 2);
        chk("sat_drop", 32'(drop_cnt), 32'd255);

        // Reset in the middle of a drain
        ack_mode = 0;
        wait_drain(100);
        run_line(384, 50, 1'b1, 2);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (line_wr && line_addr == 9'd50) found = 1'b1;
            else tick();
        end
        chk("rst_col50_reached", 32'(found), 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_line_wr", 32'(line_wr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        nwr = 0;
        run_line(384, 60, 1'b1, 5);
        wait_drain(2000);
        chk("post_rst_count", 32'(nwr), 32'd384);
        chk("post_rst_first_addr", 32'(first_w.addr), 32'd0);
        chk("post_rst_vpos", 32'(first_w.vpos), 32'd60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
